execute_stage: RTL

- Execute (x) stage of the five-phase multi-cycle core: phase bits f=4, r=3, x=2, m=1, w=0.
- Consumes rd1/rd2, the operands the register file registers during phase r.
- Computes the ALU result during phase x and holds it in a result register, which drives the register file write-data input during phase w.
- Multiply is iterative; stall holds the phase sequencer in x until the product is final.

---
 rtl/core_pkg.sv | 43 ++++
 rtl/execute_stage_if.sv | 33 +++
 rtl/execute_stage_seq_multiplier.sv | 62 ++++++
 rtl/execute_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: phase bit positions, ALU opcodes, datapath defaults
// and the execute-stage FSM encoding. Decode and register-file revisions
// import this same package.
package core_pkg;

    localparam int CORE_WIDTH = 32;
    localparam int CORE_IMM_W = 16;

    // One-hot phase bit positions: f r x m w
    localparam int PH_F = 4;
    localparam int PH_R = 3;
    localparam int PH_X = 2;
    localparam int PH_M = 1;
    localparam int PH_W = 0;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;
    localparam logic [3:0] OP_LUI = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } ex_state_e;

    // Logical ops take a zero-extended immediate instead of a sign-extended one.
    function automatic logic op_is_logical(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
    endfunction

    // Opcodes above MUL are unassigned.
    function automatic logic op_is_defined(input logic [3:0] op);
        return op <= OP_MUL;
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Execute-stage bus: phase/opcode/operand inputs from the sequencer and
// register file, result/flag/stall outputs back to them.
// Handshake: the sequencer holds phase x (and op/operands stable) for as long
// as stall is high; the result is committed on the first phase-x clock edge
// at which stall is low, and is held until the next committed execute.
interface execute_stage_if #(
    parameter int WIDTH = core_pkg::CORE_WIDTH,
    parameter int IMM_W = core_pkg::CORE_IMM_W
);
    logic [4:0]          phase;
    logic [3:0]          op;
    logic                use_imm;
    logic [IMM_W-1:0]    imm;
    logic [WIDTH-1:0]    rd1;
    logic [WIDTH-1:0]    rd2;
    logic [WIDTH-1:0]    wd;
    logic                stall;
    logic                flag_z;
    logic                flag_n;
    logic                flag_c;
    logic                op_err;
    core_pkg::ex_state_e state_dbg;

    modport master (
        output phase, op, use_imm, imm, rd1, rd2,
        input  wd, stall, flag_z, flag_n, flag_c, op_err, state_dbg
    );

    modport slave (
        input  phase, op, use_imm, imm, rd1, rd2,
        output wd, stall, flag_z, flag_n, flag_c, op_err, state_dbg
    );
endinterface

// File: rtl/execute_stage_seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per clock, WIDTH
// iterations. done is high during the last iteration and product is the
// accumulator including that final add, so the caller can load it on the
// same edge. A new start always restarts, even while busy.
module seq_multiplier #(
    parameter int WIDTH = core_pkg::CORE_WIDTH
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt;

    // Conditional add of the shifted multiplicand for the current multiplier bit
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    assign done    = busy && (cnt == CNT_LAST);
    assign product = acc_next;

    // Shift-add datapath and iteration counter
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand-B select, single-cycle ALU, flag generation, the
// IDLE/MUL_RUN control FSM and the result register that feeds the register
// file write data through phases m and w.
module execute_stage
    import core_pkg::*;
#(
    parameter int WIDTH = CORE_WIDTH,
    parameter int IMM_W = CORE_IMM_W
) (
    input logic              clk,
    input logic              n_rst,
    execute_stage_if.slave   bus
);
    ex_state_e        state;
    ex_state_e        state_next;

    logic             phase_x;
    logic             is_mul;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [4:0]       shamt;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_err;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic             stall_raw;
    logic             load_alu;
    logic             load_mul;

    logic [WIDTH-1:0] wd_q;
    logic             flag_z_q;
    logic             flag_n_q;
    logic             flag_c_q;
    logic             op_err_q;

    // A phase vector that is not one-hot still counts as x whenever bit x is set
    assign phase_x = bus.phase[PH_X];
    assign is_mul  = (bus.op == OP_MUL);
    assign op_a    = bus.rd1;
    assign shamt   = op_b[4:0];

    // Operand B: register value or immediate, extended according to the op
    always_comb begin
        op_b = bus.rd2;
        if (bus.use_imm) begin
            if (op_is_logical(bus.op)) begin
                op_b = {{(WIDTH-IMM_W){1'b0}}, bus.imm};
            end else if (bus.op == OP_LUI) begin
                op_b = {{(WIDTH-IMM_W){1'b0}}, bus.imm} << 16;
            end else begin
                op_b = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
            end
        end
    end

    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};

    // Single-cycle ALU result and carry; MUL is handled by the sub-module
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_err = !op_is_defined(bus.op);
        case (bus.op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = !diff[WIDTH];
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_SLL: alu_res = op_a << shamt;
            OP_SRL: alu_res = op_a >> shamt;
            OP_SRA: alu_res = $signed(op_a) >>> shamt;
            OP_SLT: alu_res[0] = $signed(op_a) < $signed(op_b);
            OP_LUI: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    assign mul_start = (state == ST_IDLE) && phase_x && is_mul;

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .n_rst   (n_rst),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: enter MUL_RUN on a multiply, leave on completion or when x drops
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (mul_start) begin
                    state_next = ST_MUL_RUN;
                end
            end
            ST_MUL_RUN: begin
                if (!phase_x || mul_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: stall request and which result source to commit
    always_comb begin
        stall_raw = 1'b0;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        case (state)
            ST_IDLE: begin
                stall_raw = phase_x && is_mul;
                load_alu  = phase_x && !is_mul;
            end
            ST_MUL_RUN: begin
                // mul_done implies the multiplier is busy; busy alone is informational
                stall_raw = phase_x && !mul_done;
                load_mul  = phase_x && mul_done && mul_busy;
            end
            default: ;
        endcase
    end

    // Result register and flags, held outside a committing phase-x edge
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wd_q     <= '0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_c_q <= 1'b0;
            op_err_q <= 1'b0;
        end else if (load_alu) begin
            wd_q     <= alu_res;
            flag_z_q <= (alu_res == '0);
            flag_n_q <= alu_res[WIDTH-1];
            flag_c_q <= alu_c;
            op_err_q <= alu_err;
        end else if (load_mul) begin
            wd_q     <= mul_product;
            flag_z_q <= (mul_product == '0);
            flag_n_q <= mul_product[WIDTH-1];
            flag_c_q <= 1'b0;
            op_err_q <= 1'b0;
        end
    end

    // Stall is forced low while reset is held so the sequencer is released at once
    assign bus.stall     = stall_raw && n_rst;
    assign bus.wd        = wd_q;
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_n    = flag_n_q;
    assign bus.flag_c    = flag_c_q;
    assign bus.op_err    = op_err_q;
    assign bus.state_dbg = state;

endmodule
